vardelay_buffer: RTL

VARDELAY_BUFFER -- requirements
Module: vardelay_buffer

---
 rtl/delaybuffer_pkg.sv | 18 +
 rtl/delaybuffer_ram.sv | 23 ++
 rtl/vardelay_buffer.sv | 82 ++++++++
 3 files changed

// File: rtl/delaybuffer_pkg.sv
// Shared helpers for circular-history delay blocks: pointer wrap and delay clamp.
// Plain int arithmetic so depths need not be powers of two.
package delaybuffer_pkg;

  function automatic int ptr_wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // (ptr - offset) mod depth for 0 <= ptr < depth and 0 <= offset <= depth
  function automatic int ptr_wrap_sub(input int ptr, input int offset, input int depth);
    return (ptr >= offset) ? ptr - offset : ptr + depth - offset;
  endfunction

  function automatic int clamp_delay(input int req, input int max_delay);
    return (req > max_delay) ? max_delay : req;
  endfunction

endpackage

// File: rtl/delaybuffer_ram.sv
// History store: synchronous write, asynchronous read, no reset.
module delaybuffer_ram #(
  parameter int width_p = 8,
  parameter int depth_p = 64,
  parameter int addr_w_p = 6
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [addr_w_p-1:0] waddr_i,
  input  logic [width_p-1:0]  wdata_i,
  input  logic [addr_w_p-1:0] raddr_i,
  output logic [width_p-1:0]  rdata_o
);

  logic [width_p-1:0] mem [depth_p];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/vardelay_buffer.sv
// Variable-delay stream buffer: each accepted sample emits the sample accepted
// D accepts earlier, zero-filled until enough history exists.
module vardelay_buffer
  import delaybuffer_pkg::*;
#(
  parameter int width_p = 8,
  parameter int max_delay_p = 64
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               load_i,
  input  logic [$clog2(max_delay_p+1)-1:0]   delay_i,
  input  logic                               valid_i,
  input  logic [width_p-1:0]                 data_i,
  output logic                               ready_o,
  output logic                               valid_o,
  output logic [width_p-1:0]                 data_o,
  input  logic                               ready_i,
  output logic [$clog2(max_delay_p+1)-1:0]   delay_o
);

  localparam int dw_lp = $clog2(max_delay_p + 1);
  localparam int pw_lp = (max_delay_p > 1) ? $clog2(max_delay_p) : 1;

  logic [pw_lp-1:0]   wr_ptr;
  logic [pw_lp-1:0]   rd_ptr;
  logic [dw_lp-1:0]   fill;
  logic [dw_lp-1:0]   delay_q;
  logic [width_p-1:0] rd_data;
  logic               accept;

  assign ready_o = ~flush_i & (~valid_o | ready_i);
  assign accept  = valid_i & ready_o;
  assign delay_o = delay_q;

  // With D == max_delay_p this lands on wr_ptr itself: the async read sees the
  // oldest sample before this cycle's write replaces it.
  assign rd_ptr = pw_lp'(ptr_wrap_sub(int'(wr_ptr), int'(delay_q), max_delay_p));

  delaybuffer_ram #(
    .width_p (width_p),
    .depth_p (max_delay_p),
    .addr_w_p(pw_lp)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (accept),
    .waddr_i(wr_ptr),
    .wdata_i(data_i),
    .raddr_i(rd_ptr),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      wr_ptr  <= '0;
      fill    <= '0;
      delay_q <= dw_lp'(max_delay_p);
    end else if (flush_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      wr_ptr  <= '0;
      fill    <= '0;
    end else begin
      // An accept in the load cycle still uses the old delay_q.
      if (load_i) delay_q <= dw_lp'(clamp_delay(int'(delay_i), max_delay_p));
      if (accept) begin
        valid_o <= 1'b1;
        if (delay_q == '0)     data_o <= data_i;
        else if (fill < delay_q) data_o <= '0;
        else                   data_o <= rd_data;
        wr_ptr <= pw_lp'(ptr_wrap_inc(int'(wr_ptr), max_delay_p));
        if (int'(fill) != max_delay_p) fill <= fill + dw_lp'(1);
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
